pe_edge_collector: RTL

Boundary reader for the Nanci sorting mesh. It samples the `o_PE` word driven by one edge PE on a fixed period and discards `MAX_INT` idle words. Accepted `{addr,data}` words are buffered in a small FIFO and drained to the host side over a valid/ready handshake. It is the consuming end of the PE output link, the counterpart of the neighbour `i_PE_*` inputs inside the mesh.

---
 rtl/nanci_pkg.sv | 27 ++
 rtl/nanci_sync_fifo.sv | 57 +++++
 rtl/pe_edge_collector.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/nanci_pkg.sv
// Shared definitions for the Nanci mesh boundary logic: word geometry,
// idle-word default and the collector FSM encoding.
package nanci_pkg;

    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_DATA_WIDTH = 3;

    function automatic int word_width(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

    // The PE drives all ones when it has nothing to report.
    localparam logic [DEF_ADDR_WIDTH+DEF_DATA_WIDTH-1:0] DEF_MAX_INT = '1;

    // Counter width that stays legal for the degenerate n <= 1 case.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/nanci_sync_fifo.sv
// Show-ahead synchronous FIFO; the head word is read straight out of the
// storage registers and forced to zero while empty. DEPTH must be a power of two >= 2.
module nanci_sync_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [IDX_W:0]   r_wptr;
    logic [IDX_W:0]   r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[IDX_W] != r_rptr[IDX_W]) &&
                     (r_wptr[IDX_W-1:0] == r_rptr[IDX_W-1:0]);
    assign o_count = r_wptr - r_rptr;

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign o_rdata = o_empty ? '0 : r_mem[r_rptr[IDX_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + (IDX_W+1)'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + (IDX_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[IDX_W-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/pe_edge_collector.sv
// Edge reader for the Nanci sorting mesh: samples one PE's output word on a
// fixed period, drops idle words and buffers the rest for a valid/ready host.
module pe_edge_collector
    import nanci_pkg::*;
#(
    parameter int                               ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int                               DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] MAX_INT       = {(ADDR_WIDTH+DATA_WIDTH){1'b1}},
    parameter int                               SAMPLE_PERIOD = 1,
    parameter int                               START_DELAY   = 2,
    parameter int                               N_WORDS       = 4,
    parameter int                               FIFO_DEPTH    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_start,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE,
    output logic [ADDR_WIDTH-1:0]            o_addr,
    output logic [DATA_WIDTH-1:0]            o_data,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [$clog2(FIFO_DEPTH):0]      o_count,
    output logic                             o_overflow,
    output logic                             o_done
);

    localparam int WORD_W = word_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int DLY_W  = cnt_width(START_DELAY + 1);
    localparam int PH_W   = cnt_width(SAMPLE_PERIOD);
    localparam int ACC_W  = cnt_width(N_WORDS + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DLY_W-1:0]   r_dly;
    logic [DLY_W-1:0]   w_dly_nxt;
    logic [PH_W-1:0]    r_phase;
    logic [PH_W-1:0]    w_phase_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [ACC_W-1:0]   w_acc_inc;
    logic               r_ovf;
    logic               w_ovf_nxt;

    logic               w_sample;
    logic               w_attempt;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [WORD_W-1:0]  w_head;

    assign w_sample  = (r_state == ST_SAMPLE) && (r_phase == '0);
    assign w_attempt = w_sample && (i_PE != MAX_INT);
    assign w_pop     = !w_empty && i_ready;
    // A full FIFO still takes the word when the head leaves on the same edge.
    assign w_push    = w_attempt && (!w_full || w_pop);
    assign w_acc_inc = r_acc + ACC_W'(1);

    nanci_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (i_PE),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_dly   <= '0;
            r_phase <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dly   <= w_dly_nxt;
            r_phase <= w_phase_nxt;
            r_acc   <= w_acc_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dly_nxt   = r_dly;
        w_phase_nxt = r_phase;
        w_acc_nxt   = r_acc;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_DELAY;
                    w_dly_nxt   = DLY_W'(START_DELAY);
                    w_acc_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                end
            end
            ST_DELAY: begin
                // Leaving at 1 puts the first sample START_DELAY+1 edges after start.
                if (r_dly <= DLY_W'(1)) begin
                    w_state_nxt = ST_SAMPLE;
                    w_phase_nxt = '0;
                end else begin
                    w_dly_nxt = r_dly - DLY_W'(1);
                end
            end
            ST_SAMPLE: begin
                w_phase_nxt = (r_phase == PH_W'(SAMPLE_PERIOD - 1)) ? '0 : r_phase + PH_W'(1);
                if (w_attempt) begin
                    w_acc_nxt = w_acc_inc;
                    if (!w_push) begin
                        w_ovf_nxt = 1'b1;
                    end
                    if (w_acc_inc == ACC_W'(N_WORDS)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!i_start) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_valid    = !w_empty;
    assign o_addr     = w_head[WORD_W-1 -: ADDR_WIDTH];
    assign o_data     = w_head[DATA_WIDTH-1:0];
    assign o_overflow = r_ovf;
    assign o_done     = (r_state == ST_DONE);

endmodule
